// File: rtl/pressure_pkg.sv
// Shared widths, FSM state encoding and frame parity helper for the pressure sensor reader.
// Pure declarations: no latency, no flow control.
package pressure_pkg;

   localparam int DATA_W     = 6;
   localparam int FRAME_BITS = 7;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_RDY,
      SHIFT,
      CHECK
   } state_t;

   // A frame is good when data bits plus the parity bit hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [FRAME_BITS-1:0] frame);
      return ^frame;
   endfunction

endpackage

// File: rtl/pressure_serial_shifter.sv
// Serial receive engine: phase/bit counters, registered sclk, MSB-first shift register.
// done strobes on the edge that captures the last bit; the caller must hold run until then.
module pressure_serial_shifter
   import pressure_pkg::*;
#(
   parameter int BIT_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  clear,
   input  logic                  run,
   input  logic                  sdata,
   output logic                  sclk,
   output logic [FRAME_BITS-1:0] frame,
   output logic                  done
);

   localparam int PW = $clog2(BIT_CYCLES);
   localparam int BW = $clog2(FRAME_BITS);
   localparam logic [PW-1:0] PH_LAST  = PW'(BIT_CYCLES - 1);
   localparam logic [PW-1:0] PH_HALF  = PW'(BIT_CYCLES / 2);
   localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

   logic [PW-1:0]         phase_q, phase_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [FRAME_BITS-1:0] shreg_q, shreg_d;
   logic                  sclk_q, sclk_d;
   logic                  sample;

   always_comb begin
      phase_d = phase_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      sample  = run && (phase_q == PH_LAST);
      done    = sample && (bit_q == BIT_LAST);
      if (clear) begin
         phase_d = '0;
         bit_d   = '0;
         shreg_d = '0;
      end else if (run) begin
         phase_d = sample ? '0 : phase_q + 1'b1;
         if (sample) begin
            bit_d   = bit_q + 1'b1;
            shreg_d = {shreg_q[FRAME_BITS-2:0], sdata};
         end
      end
      // sclk is registered, so it follows the phase being entered, not the current one.
      sclk_d = run && (phase_d >= PH_HALF);
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         phase_q <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         sclk_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         sclk_q  <= sclk_d;
      end
   end

   assign sclk  = sclk_q;
   assign frame = shreg_q;

endmodule

// File: rtl/pressure_sensor_reader.sv
// Pressure sensor acquisition: periodic convert handshake, 7-bit serial read, parity-checked 6-bit sample.
// pValid rises one clock after the last bit sample; no backpressure, starts are deferred while a frame is busy.
module pressure_sensor_reader
   import pressure_pkg::*;
#(
   parameter int SAMPLE_PERIOD = 1000,
   parameter int CONV_TIMEOUT  = 255,
   parameter int BIT_CYCLES    = 4
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              enable,
   input  logic              sReady,
   input  logic              sSdata,
   output logic              sConvert,
   output logic              sSclk,
   output logic [DATA_W-1:0] pData,
   output logic              pValid,
   output logic              pFault
);

   localparam int TW  = $clog2(SAMPLE_PERIOD + 1);
   localparam int TMW = $clog2(CONV_TIMEOUT + 1);
   localparam logic [TW-1:0]  TIMER_RELOAD = TW'(SAMPLE_PERIOD - 1);
   localparam logic [TMW-1:0] TMO_LAST     = TMW'(CONV_TIMEOUT - 1);

   state_t                state_q, state_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [TMW-1:0]        tmo_q, tmo_d;
   logic                  sconv_q, sconv_d;
   logic [DATA_W-1:0]     pdata_q, pdata_d;
   logic                  pvalid_q, pvalid_d;
   logic                  pfault_q, pfault_d;

   logic                  sh_clear;
   logic                  sh_run;
   logic                  sh_done;
   logic [FRAME_BITS-1:0] sh_frame;

   pressure_serial_shifter #(
      .BIT_CYCLES (BIT_CYCLES)
   ) u_shifter (
      .clk   (clk),
      .rstN  (rstN),
      .clear (sh_clear),
      .run   (sh_run),
      .sdata (sSdata),
      .sclk  (sSclk),
      .frame (sh_frame),
      .done  (sh_done)
   );

   always_comb begin
      state_d  = state_q;
      timer_d  = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
      tmo_d    = tmo_q;
      sconv_d  = sconv_q;
      pdata_d  = pdata_q;
      pvalid_d = 1'b0;
      pfault_d = pfault_q;
      sh_clear = 1'b0;
      sh_run   = (state_q == SHIFT);

      case (state_q)
         IDLE: begin
            // The timer keeps running through a frame, so a late start fires here at once.
            if ((timer_q == '0) && enable && !sReady) begin
               state_d = WAIT_RDY;
               sconv_d = 1'b1;
               tmo_d   = '0;
               timer_d = TIMER_RELOAD;
            end
         end
         WAIT_RDY: begin
            if (sReady) begin
               sconv_d  = 1'b0;
               sh_clear = 1'b1;
               state_d  = SHIFT;
            end else if (tmo_q == TMO_LAST) begin
               sconv_d  = 1'b0;
               pfault_d = 1'b1;
               state_d  = IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         SHIFT: begin
            if (sh_done) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (odd_parity_ok(sh_frame)) begin
               pdata_d  = sh_frame[FRAME_BITS-1:1];
               pvalid_d = 1'b1;
               pfault_d = 1'b0;
            end else begin
               pfault_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         tmo_q    <= '0;
         sconv_q  <= 1'b0;
         pdata_q  <= '0;
         pvalid_q <= 1'b0;
         pfault_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         tmo_q    <= tmo_d;
         sconv_q  <= sconv_d;
         pdata_q  <= pdata_d;
         pvalid_q <= pvalid_d;
         pfault_q <= pfault_d;
      end
   end

   assign sConvert = sconv_q;
   assign pData    = pdata_q;
   assign pValid   = pvalid_q;
   assign pFault   = pfault_q;

endmodule

// File: tb/tb_pressure_sensor_reader.sv
// Bench for pressure_sensor_reader: a timestamp-based reference model checked every cycle,
// plus directed sensor scenarios with hand-computed latencies, periods and sample values.
module tb_pressure_sensor_reader;

   localparam int P  = 300;
   localparam int CT = 10;
   localparam int BC = 4;

   logic       clk    = 1'b0;
   logic       rstN   = 1'b0;
   logic       enable = 1'b0;
   logic       sReady = 1'b0;
   logic       sSdata = 1'b0;
   logic       sConvert;
   logic       sSclk;
   logic [5:0] pData;
   logic       pValid;
   logic       pFault;

   int n_checks = 0;
   int n_fail   = 0;
   int ncyc     = 0;
   bit chk_on   = 1'b0;

   pressure_sensor_reader #(
      .SAMPLE_PERIOD (P),
      .CONV_TIMEOUT  (CT),
      .BIT_CYCLES    (BC)
   ) dut (
      .clk      (clk),
      .rstN     (rstN),
      .enable   (enable),
      .sReady   (sReady),
      .sSdata   (sSdata),
      .sConvert (sConvert),
      .sSclk    (sSclk),
      .pData    (pData),
      .pValid   (pValid),
      .pFault   (pFault)
   );

   always #5 clk = ~clk;
   always @(posedge clk) ncyc <= ncyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, ncyc);
      end
   endtask

   // Reference model: tracks absolute edge numbers of the last start and of the
   // sReady acceptance, and derives every output from offsets to those instants.
   typedef enum int {M_IDLE, M_WAIT, M_FRAME} mmode_t;
   mmode_t     m_mode       = M_IDLE;
   int         m_edge       = 0;
   int         m_last_start = -1000000;
   int         m_start      = 0;
   int         m_f          = 0;
   int         m_k          = 0;
   int         m_ones       = 0;
   int         m_val        = 0;
   int         m_bits [7];
   logic       m_conv   = 1'b0;
   logic       m_sclk   = 1'b0;
   logic       m_pvalid = 1'b0;
   logic       m_pfault = 1'b0;
   logic [5:0] m_pdata  = 6'd0;

   initial forever begin
      @(posedge clk or negedge rstN);
      if (!rstN) begin
         m_mode       = M_IDLE;
         m_edge       = 0;
         m_last_start = -1000000;
         m_conv       = 1'b0;
         m_sclk       = 1'b0;
         m_pvalid     = 1'b0;
         m_pfault     = 1'b0;
         m_pdata      = 6'd0;
      end else begin
         m_edge++;
         m_pvalid = 1'b0;
         m_sclk   = 1'b0;
         case (m_mode)
            M_IDLE: begin
               if ((m_edge - m_last_start >= P) && enable && !sReady) begin
                  m_mode       = M_WAIT;
                  m_start      = m_edge;
                  m_last_start = m_edge;
                  m_conv       = 1'b1;
               end
            end
            M_WAIT: begin
               if (sReady) begin
                  m_mode = M_FRAME;
                  m_f    = m_edge;
                  m_conv = 1'b0;
               end else if (m_edge - m_start == CT) begin
                  m_mode   = M_IDLE;
                  m_conv   = 1'b0;
                  m_pfault = 1'b1;
               end
            end
            default: begin
               m_k = m_edge - m_f;
               if ((m_k % BC == 0) && (m_k <= 7 * BC)) m_bits[m_k / BC - 1] = sSdata ? 1 : 0;
               if (m_k < 7 * BC) m_sclk = (m_k % BC) >= (BC / 2);
               if (m_k == 7 * BC + 1) begin
                  m_ones = 0;
                  m_val  = 0;
                  for (int b = 0; b < 7; b++) m_ones += m_bits[b];
                  for (int b = 0; b < 6; b++) m_val = m_val * 2 + m_bits[b];
                  if (m_ones % 2 == 1) begin
                     m_pdata  = 6'(m_val);
                     m_pvalid = 1'b1;
                     m_pfault = 1'b0;
                  end else begin
                     m_pfault = 1'b1;
                  end
                  m_mode = M_IDLE;
               end
            end
         endcase
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         chk("cyc_sConvert", sConvert, m_conv);
         chk("cyc_sSclk",    sSclk,    m_sclk);
         chk("cyc_pData",    pData,    m_pdata);
         chk("cyc_pValid",   pValid,   m_pvalid);
         chk("cyc_pFault",   pFault,   m_pfault);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_start(input int limit, output int t);
      t = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (sConvert === 1'b1) begin
            t = ncyc;
            break;
         end
      end
      chk("start_seen", (t >= 0), 1);
   endtask

   // Sensor: raises sReady after 'delay' cycles, then drives the 7 frame bits MSB first,
   // each held BC cycles. Reports the cycle of the first pValid and the pulse count.
   task automatic do_frame(input logic [6:0] fr, input int delay, input bit hold,
                           input int drop_en_bit, input int rst_bit,
                           output int pv_lat, output int pv_cnt);
      pv_lat = -1;
      pv_cnt = 0;
      repeat (delay) @(negedge clk);
      sReady = 1'b1;
      for (int n = 1; n <= 34; n++) begin
         @(negedge clk);
         if (pValid) begin
            if (pv_lat < 0) pv_lat = n;
            pv_cnt++;
         end
         if (n == 1 && !hold) sReady = 1'b0;
         if (n <= 1 + 6 * BC && (n - 1) % BC == 0) sSdata = fr[6 - (n - 1) / BC];
         if (drop_en_bit >= 0 && n == 1 + BC * drop_en_bit) enable = 1'b0;
         if (rst_bit >= 0 && n == 3 + BC * rst_bit) begin
            #2 rstN = 1'b0;
            return;
         end
      end
   endtask

   initial begin
      int s1, s2, s3, s4, s5, lat, cnt, hi;

      repeat (2) @(negedge clk);
      chk_on = 1'b1;
      chk("rst_sConvert", sConvert, 0);
      chk("rst_sSclk",    sSclk,    0);
      chk("rst_pData",    pData,    0);
      chk("rst_pValid",   pValid,   0);
      chk("rst_pFault",   pFault,   0);

      @(negedge clk);
      rstN   = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      chk("first_start", sConvert, 1);
      s1 = ncyc;

      // Good frame 100011 + parity 0.
      do_frame(7'b1000110, 3, 1'b0, -1, -1, lat, cnt);
      chk("good_latency", lat, 30);
      chk("good_pulses",  cnt, 1);
      chk("good_pData",   pData, 6'b100011);
      chk("good_pFault",  pFault, 0);

      // Bad parity: 100011 + parity 1.
      wait_start(400, s2);
      chk("period_1", s2 - s1, P);
      do_frame(7'b1000111, 2, 1'b0, -1, -1, lat, cnt);
      chk("bad_pulses",     cnt, 0);
      chk("bad_pFault",     pFault, 1);
      chk("bad_pData_held", pData, 6'b100011);

      // Recovery: 010000 + parity 0.
      wait_start(400, s3);
      chk("period_2", s3 - s2, P);
      do_frame(7'b0100000, 1, 1'b0, -1, -1, lat, cnt);
      chk("recover_latency", lat, 30);
      chk("recover_pulses",  cnt, 1);
      chk("recover_pData",   pData, 6'b010000);
      chk("recover_pFault",  pFault, 0);

      // Timeout: sensor never answers.
      wait_start(400, s4);
      chk("period_3", s4 - s3, P);
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         if (sConvert) hi++;
         @(negedge clk);
      end
      chk("timeout_conv_width", hi, CT);
      chk("timeout_pFault",     pFault, 1);
      wait_start(400, s5);
      chk("timeout_period", s5 - s4, P);

      // Handshake: sReady left high past the timer expiry defers the next start.
      do_frame(7'b0010110, 2, 1'b1, -1, -1, lat, cnt);
      chk("hold_pulses", cnt, 1);
      chk("hold_pData",  pData, 6'b001011);
      hi = 0;
      while (ncyc < s5 + P + 10) begin
         @(negedge clk);
         if (sConvert) hi++;
      end
      chk("hold_no_start", hi, 0);
      sReady = 1'b0;
      @(negedge clk);
      chk("start_after_drop", sConvert, 1);

      // enable drops at bit 3: frame still completes, then no more starts.
      do_frame(7'b0110100, 1, 1'b0, 3, -1, lat, cnt);
      chk("endrop_latency", lat, 30);
      chk("endrop_pulses",  cnt, 1);
      chk("endrop_pData",   pData, 6'b011010);
      hi = 0;
      repeat (400) begin
         @(negedge clk);
         if (sConvert) hi++;
      end
      chk("disabled_no_start", hi, 0);

      // Reset pulsed during bit 4 while sclk is high.
      enable = 1'b1;
      @(negedge clk);
      chk("reenable_start", sConvert, 1);
      do_frame(7'b1111111, 2, 1'b0, -1, 4, lat, cnt);
      #1;
      chk("midrst_sConvert", sConvert, 0);
      chk("midrst_sSclk",    sSclk,    0);
      chk("midrst_pData",    pData,    0);
      chk("midrst_pValid",   pValid,   0);
      chk("midrst_pFault",   pFault,   0);
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      chk("post_reset_start", sConvert, 1);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
